dcache_refill: RTL

Miss-handling refill engine for the direct-mapped data cache. On a lookup miss it stalls the core, issues one block-read request to the memory side, and collects BLOCK_SIZE word beats into a line buffer. It then presents the assembled block to the cache with a one-cycle write pulse. It sits between the cache (drives its write_en/addr/data_in during fill) and the word-wide memory port.

---
 rtl/dcache_refill.sv | 91 +++++++++
 1 files changed

// File: rtl/dcache_refill.sv
// Miss-handling refill engine: on a cache miss, requests one block from memory,
// gathers BLOCK_SIZE word beats into a line buffer, then pulses a single cache fill.
module dcache_refill #(
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                             clk,
    input  logic                             arst_n,
    input  logic                             miss_valid,
    input  logic [DATA_WIDTH-1:0]            miss_addr,
    output logic                             stall,
    output logic                             mem_req,
    output logic [DATA_WIDTH-1:0]            mem_addr,
    input  logic                             mem_gnt,
    input  logic                             mem_rvalid,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic                             fill_en,
    output logic [DATA_WIDTH-1:0]            fill_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] fill_data
);

    localparam int OFFSET_BITS = $clog2(BLOCK_SIZE) + 2;
    localparam int CNT_W       = $clog2(BLOCK_SIZE);
    localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [DATA_WIDTH-1:0] OFFSET_MASK = DATA_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RECV = 2'd2,
        FILL = 2'd3
    } state_t;

    state_t                               state;
    logic [DATA_WIDTH-1:0]                base;
    logic [CNT_W-1:0]                     cnt;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] line;

    // Request/fill handshake: mem_req rises on entry to REQ and stays high, with
    // mem_addr constant, up to and including the cycle mem_gnt is seen. Beats are
    // accepted only in RECV, i.e. starting the cycle after the grant.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state   <= IDLE;
            base    <= '0;
            cnt     <= '0;
            line    <= '0;
            mem_req <= 1'b0;
            fill_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_valid) begin
                        base    <= miss_addr & ~OFFSET_MASK;
                        cnt     <= '0;
                        mem_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= RECV;
                    end
                end
                RECV: begin
                    if (mem_rvalid) begin
                        line[cnt] <= mem_rdata;
                        cnt       <= cnt + CNT_W'(1);
                        if (cnt == LAST_BEAT) begin
                            fill_en <= 1'b1;
                            state   <= FILL;
                        end
                    end
                end
                FILL: begin
                    fill_en <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Combinational so the core freezes in the very cycle the miss is reported.
    assign stall     = (state != IDLE) | miss_valid;
    assign mem_addr  = base;
    assign fill_addr = base;
    assign fill_data = line;

endmodule
